simplebus_mem_responder: RTL and testbench
==========================================

# simplebus_mem_responder

Synthesizable SimpleBus responder: accepts requests on the req channel, services them from an internal 64-bit-wide word memory, and returns responses on the resp channel after a fixed latency. It is the slave end of the bus the NutShell cache drives. It serves as the backing store behind the cache in the UVM environment and as a drop-in memory for standalone bring-up.

## Interface
- DEPTH, 1024, number of 64-bit words; power of two, at least 4
- LATENCY, 2, cycles from request acceptance to the first response beat; at least 1
- clock  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 resets the block)
- req_ready  out  1  responder can accept a request beat
- req_valid  in  1  request beat present
- req_addr  in  32  byte address; word index = req_addr[log2(DEPTH)+2:3]
- req_size  in  3  access size; ignored, because req_wmask governs writes
- req_cmd  in  4  0000 read, 0001 write, 0010 readBurst, 0011 writeBurst, 0111 writeLast, 0100 prefetch, 1000 probe
- req_wmask  in  8  byte enables for writes, bit i enables wdata[8i+7:8i]
- req_wdata  in  64  write data
- req_user  in  16  opaque tag; echoed on resp_user
- resp_ready  in  1  initiator accepts a response beat
- resp_valid  out  1  response beat present
- resp_cmd  out  4  0000 read (non-last burst beat), 0110 readLast, 0101 writeResp, 1000 probeMiss
- resp_rdata  out  64  read data; 0 for write and probe responses
- resp_user  out  16  req_user captured at the first beat of the transaction

## Operation
- The memory array holds DEPTH×64 bits and is not cleared by reset.
- Out-of-range addresses wrap modulo DEPTH.
- The block has one outstanding transaction. FSM states are IDLE, WBURST, WAIT and RESP.
- IDLE: req_ready=1. On a handshake (req_valid & req_ready), capture the word index, req_user and the transaction kind.
  - read or prefetch: go to WAIT with beats=1.
  - readBurst: go to WAIT with beats=4.
  - write: apply the masked write on this edge, then go to WAIT.
  - writeBurst: apply the masked write to the captured index, then go to WBURST with beat counter=1.
  - writeLast while in IDLE: handled as a write.
  - probe: see Configuration.
- WBURST: req_ready=1. Each accepted beat is written to the aligned 4-word block at index (base & ~3) | ((base+cnt) & 3), and cnt increments mod 4; the beat's req_addr is ignored.
  - On writeLast: go to WAIT.
  - Any other cmd while in WBURST is treated as writeLast.
  - More than 4 beats wrap and overwrite within the block.
- WAIT: req_ready=0. A down-counter loads LATENCY-1 on entry and exits to RESP when it reaches 0.
- RESP: req_ready=0 and resp_valid=1.
  - Read beats: resp_rdata = mem[(base & ~3) | ((base+k) & 3)] for beat k = 0..beats-1. For a single read, k=0 gives mem[base].
  - Burst read order is critical-word-first with wrap inside the aligned 4-word block.
  - Non-last burst beats carry cmd 0000; the last beat (and a single read) carries 0110.
  - Write transactions give one beat with cmd 0101 and rdata 0.
  - Advance on resp_valid & resp_ready. After the last beat, go to IDLE.
- Read data is sampled from memory when the beat is presented, so it reflects all earlier writes.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_cmd=0, resp_rdata=0, resp_user=0, FSM=IDLE.
- The first edge after reset deasserts leaves req_ready=1.
- Reset asserted mid-transaction aborts the transaction immediately. Partial burst writes already applied stay in memory.
- If a request is accepted at edge T, the first response beat has resp_valid=1 in the cycle after edge T+LATENCY-1.
  - For writeBurst, T is the writeLast edge.
- While resp_valid=1 and resp_ready=0, resp_cmd, resp_rdata and resp_user hold stable.
- Burst read beats go out back-to-back when resp_ready is held high: 4 beats in 4 consecutive cycles.
- After the final response handshake at edge E, req_ready=1 in the cycle after E.
- A new request is never accepted in the same cycle as a response handshake.
- All outputs are registered. There is no combinational path from req_valid or resp_ready to any output.

## Configuration
- SIMPLEBUS_RESP_PROBE_EN defined: cmd 1000 (probe) goes straight from IDLE to WAIT with no memory access. It produces one beat with cmd 1000 (probeMiss), rdata 0 and user echoed.
- Not defined: probe is treated exactly as a single read, returning readLast with mem[index].

## Test plan
- Write then read: LATENCY=2, write addr 0x40, wmask 0xFF, wdata 0x1122334455667788, user 0x00A5 -> writeResp beat with user 0x00A5. A subsequent read of 0x40 -> readLast, rdata 0x1122334455667788, resp_valid exactly 2 cycles after acceptance.
- Partial mask: memory word at 0x40 = 0x1122334455667788; write 0x40 with wmask 0x0F and wdata 0xFFFFFFFFFFFFFFFF -> read 0x40 returns 0x11223344FFFFFFFF.
- Wrap burst: words 0x00..0x18 preloaded with 0..3 via single writes; readBurst at 0x10 -> beats 2,3,0,1 with cmds 0000,0000,0000,0110.
- Backpressure: during a readBurst, resp_ready is held 0 for 5 cycles on beat 1 -> beat 1 data and cmd stay stable, and req_ready stays 0 throughout.
- Write burst: writeBurst at 0x28 with data A, then writeBurst B, writeBurst C, writeLast D -> exactly one writeResp. readBurst at 0x20 returns D, A, B, C.
- Reset mid-op: reset pulled low while a burst read is in RESP beat 2 -> resp_valid=0 immediately. After release, req_ready=1 and the memory contents are intact.

Source files
------------

// File: rtl/simplebus_mem_responder.sv
// simplebus_mem_responder
//   SimpleBus slave backed by an internal DEPTH x 64-bit word memory. One
//   transaction outstanding at a time; the first response beat appears a
//   fixed LATENCY cycles after the request (or writeLast) is accepted.
//
// Parameters
//   DEPTH    number of 64-bit words (power of two, >= 4)
//   LATENCY  cycles from acceptance to first response beat (>= 1)
//
// Ports
//   clock, reset                rising-edge clock, asynchronous active-low reset
//   req_ready/req_valid         request handshake
//   req_addr/size/cmd/wmask/
//   req_wdata/req_user          request beat fields (req_size is ignored)
//   resp_ready/resp_valid       response handshake
//   resp_cmd/rdata/user         response beat fields (all registered)
//
// Build option
//   SIMPLEBUS_RESP_PROBE_EN     probe answers probeMiss without touching memory;
//                               undefined: probe behaves as a single read.

module simplebus_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        req_ready,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_cmd,
  input  logic [7:0]  req_wmask,
  input  logic [63:0] req_wdata,
  input  logic [15:0] req_user,
  input  logic        resp_ready,
  output logic        resp_valid,
  output logic [3:0]  resp_cmd,
  output logic [63:0] resp_rdata,
  output logic [15:0] resp_user
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned WAIT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

  localparam logic [3:0] CMD_READ     = 4'b0000;
  localparam logic [3:0] CMD_WRITE    = 4'b0001;
  localparam logic [3:0] CMD_RBURST   = 4'b0010;
  localparam logic [3:0] CMD_WBURST   = 4'b0011;
  localparam logic [3:0] CMD_PREFETCH = 4'b0100;
  localparam logic [3:0] CMD_WLAST    = 4'b0111;
  localparam logic [3:0] CMD_PROBE    = 4'b1000;

  localparam logic [3:0] RSP_READ      = 4'b0000;
  localparam logic [3:0] RSP_READLAST  = 4'b0110;
  localparam logic [3:0] RSP_WRESP     = 4'b0101;
  localparam logic [3:0] RSP_PROBEMISS = 4'b1000;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WBURST = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] K_READ  = 2'd0;
  localparam logic [1:0] K_WRITE = 2'd1;
  localparam logic [1:0] K_PROBE = 2'd2;

  logic [63:0]   mem [DEPTH];

  logic [1:0]    state_q;
  logic [AW-1:0] base_q;
  logic [1:0]    kind_q;
  logic          burst_q;
  logic [1:0]    beat_q;
  logic [1:0]    wcnt_q;
  logic [CW-1:0] wait_q;

  logic          acc;
  logic [AW-1:0] idx_in;
  logic [1:0]    req_kind;
  logic          req_burst;
  logic          req_wb_start;
  logic          req_is_write;
  logic          start_txn;
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [AW-1:0] sel_base;
  logic [1:0]    sel_kind;
  logic          sel_burst;
  logic [3:0]    first_cmd;
  logic [63:0]   first_rdata;
  logic [1:0]    next_beat;
  logic [3:0]    next_cmd;
  logic [63:0]   next_rdata;
  logic          unused_bits;

  assign unused_bits = ^{req_size, req_addr[31:AW+3], req_addr[2:0]};

  // Word index inside the aligned 4-word block containing base.
  function automatic logic [AW-1:0] blk_idx(input logic [AW-1:0] base,
                                            input logic [1:0]    off);
    logic [1:0] lo;
    lo = base[1:0] + off;
    return (base & ~AW'(3)) | AW'(lo);
  endfunction

  assign acc    = req_valid & req_ready;
  assign idx_in = req_addr[AW+2:3];

  always_comb begin
    req_kind     = K_READ;
    req_burst    = 1'b0;
    req_wb_start = 1'b0;
    req_is_write = 1'b0;
    case (req_cmd)
      CMD_RBURST: req_burst = 1'b1;
      CMD_WRITE, CMD_WLAST: begin
        req_kind     = K_WRITE;
        req_is_write = 1'b1;
      end
      CMD_WBURST: begin
        req_kind     = K_WRITE;
        req_is_write = 1'b1;
        req_wb_start = 1'b1;
      end
`ifdef SIMPLEBUS_RESP_PROBE_EN
      CMD_PROBE: req_kind = K_PROBE;
`else
      CMD_PROBE: req_kind = K_READ;
`endif
      default: req_kind = K_READ;
    endcase
  end

  assign start_txn = acc && (((state_q == S_IDLE) && !req_wb_start) ||
                             ((state_q == S_WBURST) && (req_cmd != CMD_WBURST)));

  always_comb begin
    mem_we   = 1'b0;
    mem_widx = idx_in;
    if (acc && (state_q == S_IDLE) && req_is_write) begin
      mem_we = 1'b1;
    end
    if (acc && (state_q == S_WBURST)) begin
      mem_we   = 1'b1;
      mem_widx = blk_idx(base_q, wcnt_q);
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (req_wmask[b]) mem[mem_widx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // First beat is built from the live request in IDLE (LATENCY==1 case)
  // and from the captured transaction otherwise.
  always_comb begin
    sel_base    = (state_q == S_IDLE) ? idx_in    : base_q;
    sel_kind    = (state_q == S_IDLE) ? req_kind  : kind_q;
    sel_burst   = (state_q == S_IDLE) ? req_burst : burst_q;
    first_cmd   = RSP_READLAST;
    first_rdata = '0;
    case (sel_kind)
      K_WRITE: first_cmd = RSP_WRESP;
      K_PROBE: first_cmd = RSP_PROBEMISS;
      default: begin
        first_cmd   = sel_burst ? RSP_READ : RSP_READLAST;
        first_rdata = mem[sel_base];
      end
    endcase
  end

  assign next_beat  = beat_q + 2'd1;
  assign next_cmd   = (next_beat == 2'd3) ? RSP_READLAST : RSP_READ;
  assign next_rdata = mem[blk_idx(base_q, next_beat)];

  // The wait counter is held one below the nominal LATENCY-1 countdown so the
  // registered resp_valid rises exactly LATENCY cycles after acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_cmd   <= '0;
      resp_rdata <= '0;
      resp_user  <= '0;
      base_q     <= '0;
      kind_q     <= K_READ;
      burst_q    <= 1'b0;
      beat_q     <= '0;
      wcnt_q     <= '0;
      wait_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (acc) begin
            base_q    <= idx_in;
            resp_user <= req_user;
            kind_q    <= req_kind;
            burst_q   <= req_burst;
            beat_q    <= '0;
            if (req_wb_start) begin
              state_q <= S_WBURST;
              wcnt_q  <= 2'd1;
            end
          end
        end
        S_WBURST: begin
          if (acc) wcnt_q <= wcnt_q + 2'd1;
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            state_q    <= S_RESP;
            resp_valid <= 1'b1;
            resp_cmd   <= first_cmd;
            resp_rdata <= first_rdata;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            if (!burst_q || (beat_q == 2'd3)) begin
              state_q    <= S_IDLE;
              resp_valid <= 1'b0;
              req_ready  <= 1'b1;
            end else begin
              beat_q     <= next_beat;
              resp_cmd   <= next_cmd;
              resp_rdata <= next_rdata;
            end
          end
        end
      endcase

      // Transaction start overrides the per-state defaults above.
      if (start_txn) begin
        req_ready <= 1'b0;
        if (LATENCY == 1) begin
          state_q    <= S_RESP;
          resp_valid <= 1'b1;
          resp_cmd   <= first_cmd;
          resp_rdata <= first_rdata;
        end else begin
          state_q <= S_WAIT;
          wait_q  <= CW'(WAIT_INIT);
        end
      end
    end
  end

endmodule

// File: tb/tb_simplebus_mem_responder.sv
// Self-checking bench for simplebus_mem_responder (DEPTH=1024, LATENCY=2).
module tb_simplebus_mem_responder;

  localparam int LAT = 2;

  localparam logic [3:0] C_READ = 4'b0000, C_WRITE = 4'b0001, C_RBURST = 4'b0010,
                         C_WBURST = 4'b0011, C_WLAST = 4'b0111, C_PREF = 4'b0100,
                         C_PROBE = 4'b1000;
  localparam logic [3:0] R_READ = 4'b0000, R_LAST = 4'b0110, R_WRESP = 4'b0101,
                         R_PMISS = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_ready, req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_cmd;
  logic [7:0]  req_wmask;
  logic [63:0] req_wdata;
  logic [15:0] req_user;
  logic        resp_ready, resp_valid;
  logic [3:0]  resp_cmd;
  logic [63:0] resp_rdata;
  logic [15:0] resp_user;

  simplebus_mem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clock(clk), .reset(rst_n),
    .req_ready(req_ready), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_cmd(req_cmd), .req_wmask(req_wmask),
    .req_wdata(req_wdata), .req_user(req_user),
    .resp_ready(resp_ready), .resp_valid(resp_valid), .resp_cmd(resp_cmd),
    .resp_rdata(resp_rdata), .resp_user(resp_user)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [63:0] rdata;
    logic [15:0] user;
  } resp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [15:0] user;
    logic [3:0]  exp_cmd;
    logic [63:0] exp_rdata;
  } vec_t;

  resp_t exp_q[$];
  vec_t  vecs[16];
  int    n_checks = 0;
  int    n_fail = 0;

  localparam logic [63:0] DA = 64'hAAAA_0000_0000_000A, DB = 64'hBBBB_0000_0000_000B,
                          DC = 64'hCCCC_0000_0000_000C, DD = 64'hDDDD_0000_0000_000D;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [63:0] d, input logic [15:0] u);
    resp_t r;
    r.cmd = c; r.rdata = d; r.user = u;
    exp_q.push_back(r);
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic do_req(input logic [3:0] c, input logic [31:0] a, input logic [7:0] m,
                        input logic [63:0] d, input logic [15:0] u);
    int t = 0;
    req_valid = 1'b1; req_cmd = c; req_addr = a; req_wmask = m; req_wdata = d; req_user = u;
    req_size = 3'd3;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL req_accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, t);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_latency(input string name);
    int lat = 1;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    check({name, "_latency"}, 64'(lat), 64'(LAT));
  endtask

  task automatic get_resp(input string name, output int waits);
    resp_t e;
    waits = 0;
    while (!resp_valid && waits < 40) begin @(negedge clk); waits++; end
    if (!resp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: resp_valid=0 after %0d cycles, required 1", name, waits);
      return;
    end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_unexpected: resp_cmd=%h with no response expected", name, resp_cmd);
    end else begin
      e = exp_q.pop_front();
      check({name, "_cmd"},   64'(resp_cmd),  64'(e.cmd));
      check({name, "_rdata"}, resp_rdata,     e.rdata);
      check({name, "_user"},  64'(resp_user), 64'(e.user));
    end
    @(negedge clk);
  endtask

  task automatic single(input string name, input logic [3:0] c, input logic [31:0] a,
                        input logic [7:0] m, input logic [63:0] d, input logic [15:0] u,
                        input logic [3:0] ec, input logic [63:0] ed);
    int w;
    push(ec, ed, u);
    do_req(c, a, m, d, u);
    check_latency(name);
    get_resp(name, w);
  endtask

  task automatic burst_read(input string name, input logic [31:0] a, input logic [15:0] u,
                            input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3);
    push(R_READ, d0, u); push(R_READ, d1, u); push(R_READ, d2, u); push(R_LAST, d3, u);
    do_req(C_RBURST, a, 8'h00, '0, u);
    check_latency(name);
  endtask

  initial begin
    int w;
    req_valid = 0; req_addr = '0; req_size = '0; req_cmd = '0; req_wmask = '0;
    req_wdata = '0; req_user = '0; resp_ready = 1'b1;

    vecs[0]  = '{C_WRITE, 32'h40,   8'hFF, 64'h1122334455667788, 16'h00A5, R_WRESP, 64'h0};
    vecs[1]  = '{C_READ,  32'h40,   8'h00, 64'h0,                16'h0001, R_LAST,  64'h1122334455667788};
    vecs[2]  = '{C_WRITE, 32'h40,   8'h0F, 64'hFFFFFFFFFFFFFFFF, 16'h0002, R_WRESP, 64'h0};
    vecs[3]  = '{C_READ,  32'h40,   8'h00, 64'h0,                16'h0003, R_LAST,  64'h11223344FFFFFFFF};
    vecs[4]  = '{C_WRITE, 32'h00,   8'hFF, 64'h0,                16'h0004, R_WRESP, 64'h0};
    vecs[5]  = '{C_WRITE, 32'h08,   8'hFF, 64'h1,                16'h0005, R_WRESP, 64'h0};
    vecs[6]  = '{C_WRITE, 32'h10,   8'hFF, 64'h2,                16'h0006, R_WRESP, 64'h0};
    vecs[7]  = '{C_WRITE, 32'h18,   8'hFF, 64'h3,                16'h0007, R_WRESP, 64'h0};
    vecs[8]  = '{C_PREF,  32'h18,   8'h00, 64'h0,                16'h0008, R_LAST,  64'h3};
    vecs[9]  = '{C_READ,  32'h2008, 8'h00, 64'h0,                16'h0009, R_LAST,  64'h1};
`ifdef SIMPLEBUS_RESP_PROBE_EN
    vecs[10] = '{C_PROBE, 32'h08,   8'h00, 64'h0,                16'h000A, R_PMISS, 64'h0};
`else
    vecs[10] = '{C_PROBE, 32'h08,   8'h00, 64'h0,                16'h000A, R_LAST,  64'h1};
`endif
    vecs[11] = '{C_WRITE, 32'h48,   8'hFF, 64'h0102030405060708, 16'h000B, R_WRESP, 64'h0};
    vecs[12] = '{C_WRITE, 32'h48,   8'h80, 64'hABCDEF0123456789, 16'h000C, R_WRESP, 64'h0};
    vecs[13] = '{C_READ,  32'h48,   8'h00, 64'h0,                16'h000D, R_LAST,  64'hAB02030405060708};
    vecs[14] = '{C_WLAST, 32'h50,   8'hFF, 64'h5555AAAA5555AAAA, 16'h000E, R_WRESP, 64'h0};
    vecs[15] = '{C_READ,  32'h50,   8'h00, 64'h0,                16'h000F, R_LAST,  64'h5555AAAA5555AAAA};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready",  64'(req_ready),  64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_cmd",   64'(resp_cmd),   64'h0);
    check("rst_resp_rdata", resp_rdata,      64'h0);
    check("rst_resp_user",  64'(resp_user),  64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'h1);

    // Single-beat vectors
    for (int i = 0; i < 16; i++) begin
      single($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].wmask,
             vecs[i].wdata, vecs[i].user, vecs[i].exp_cmd, vecs[i].exp_rdata);
    end

    // Wrap burst, critical word first, back-to-back beats
    burst_read("wrap", 32'h10, 16'h0010, 64'h2, 64'h3, 64'h0, 64'h1);
    for (int k = 0; k < 4; k++) begin
      get_resp($sformatf("wrap_beat%0d", k), w);
      if (k > 0) check($sformatf("wrap_b2b%0d", k), 64'(w), 64'h0);
    end

    // Backpressure on beat 1
    burst_read("bp", 32'h10, 16'h0011, 64'h2, 64'h3, 64'h0, 64'h1);
    get_resp("bp_beat0", w);
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d_valid", i), 64'(resp_valid), 64'h1);
      check($sformatf("bp_hold%0d_cmd", i),   64'(resp_cmd),   64'(R_READ));
      check($sformatf("bp_hold%0d_rdata", i), resp_rdata,      64'h3);
      check($sformatf("bp_hold%0d_user", i),  64'(resp_user),  64'h0011);
      check($sformatf("bp_hold%0d_rdy", i),   64'(req_ready),  64'h0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    for (int k = 1; k < 4; k++) get_resp($sformatf("bp_beat%0d", k), w);

    // Write burst starting at word 5, wrapping inside words 4..7
    do_req(C_WBURST, 32'h28, 8'hFF, DA, 16'h0028);
    check("wb0_valid", 64'(resp_valid), 64'h0);
    check("wb0_rdy",   64'(req_ready),  64'h1);
    do_req(C_WBURST, 32'h999, 8'hFF, DB, 16'h0999);
    check("wb1_valid", 64'(resp_valid), 64'h0);
    do_req(C_WBURST, 32'h0, 8'hFF, DC, 16'h0999);
    check("wb2_valid", 64'(resp_valid), 64'h0);
    push(R_WRESP, 64'h0, 16'h0028);
    do_req(C_WLAST, 32'h0, 8'hFF, DD, 16'h0999);
    check_latency("wb_last");
    get_resp("wb_resp", w);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wb_single_resp%0d", i), 64'(resp_valid), 64'h0);
      @(negedge clk);
    end
    check("wb_idle_rdy", 64'(req_ready), 64'h1);
    burst_read("wb_rd", 32'h20, 16'h0020, DD, DA, DB, DC);
    for (int k = 0; k < 4; k++) get_resp($sformatf("wb_rd_beat%0d", k), w);

    // Reset during beat 2 of a burst read
    burst_read("rst", 32'h10, 16'h0077, 64'h2, 64'h3, 64'h0, 64'h1);
    get_resp("rst_beat0", w);
    get_resp("rst_beat1", w);
    check("rst_pre_valid", 64'(resp_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check("rst_abort_valid", 64'(resp_valid), 64'h0);
    check("rst_abort_rdy",   64'(req_ready),  64'h0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_rdy",   64'(req_ready),  64'h1);
    check("rst_rel_valid", 64'(resp_valid), 64'h0);
    single("keep0", C_READ, 32'h20, 8'h00, '0, 16'h0101, R_LAST, DD);
    single("keep1", C_READ, 32'h10, 8'h00, '0, 16'h0102, R_LAST, 64'h2);
    single("keep2", C_READ, 32'h48, 8'h00, '0, 16'h0103, R_LAST, 64'hAB02030405060708);
    single("keep3", C_READ, 32'h28, 8'h00, '0, 16'h0104, R_LAST, DA);

    check("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
